// File: rtl/sfifo_pkg.sv
// Shared constants and types for the sfifo round-robin arbiter.
package sfifo_pkg;

  localparam int SFIFO_COUNT = 4;
  localparam int SFIFO_WIDTH = 32;

  // Packet-lock state; used only when SFIFO_ARB_LOCK_EN is defined.
  typedef enum logic {
    LOCK_IDLE   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/sfifo_rr_pick.sv
// Combinational round-robin pick: first valid requester after pointer,
// wrapping modulo COUNT. Outputs a one-hot grant and its index.
module sfifo_rr_pick #(
  parameter int COUNT = 4
) (
  input  logic [COUNT-1:0]         valid,
  input  logic [$clog2(COUNT)-1:0] pointer,
  output logic [COUNT-1:0]         grant,
  output logic [$clog2(COUNT)-1:0] index
);

  localparam int IW = $clog2(COUNT);

  // Scan pointer+1 .. pointer+COUNT and take the first valid requester.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    grant = '0;
    index = '0;
    for (int k = 1; k <= COUNT; k++) begin
      int idx;
      idx = (int'(pointer) + k) % COUNT;
      if (grant == '0 && valid[idx]) begin
        grant[idx] = 1'b1;
        index      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/sfifo_rr_arbiter.sv
// Round-robin arbiter feeding a single registered sfifo sender slot.
// Optional packet locking is enabled by defining SFIFO_ARB_LOCK_EN.
module sfifo_rr_arbiter
  import sfifo_pkg::*;
#(
  parameter int COUNT = SFIFO_COUNT,
  parameter int WIDTH = SFIFO_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [COUNT*WIDTH-1:0]   receiver_data,
  input  logic [COUNT-1:0]         receiver_valid,
  output logic [COUNT-1:0]         receiver_ready,
`ifdef SFIFO_ARB_LOCK_EN
  input  logic [COUNT-1:0]         receiver_last,
`endif
  output logic [WIDTH-1:0]         sender_data,
  output logic                     sender_valid,
  input  logic                     sender_ready,
  output logic [$clog2(COUNT)-1:0] sender_source
);

  localparam int IW = $clog2(COUNT);

  logic [IW-1:0]    pointer;
  logic [COUNT-1:0] pick_grant;
  logic [IW-1:0]    pick_index;
  logic [COUNT-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             slot_free;
  logic             rx_fire;

  sfifo_rr_pick #(.COUNT(COUNT)) u_pick (
    .valid   (receiver_valid),
    .pointer (pointer),
    .grant   (pick_grant),
    .index   (pick_index)
  );

`ifdef SFIFO_ARB_LOCK_EN
  lock_state_e state, state_next;
  logic [IW-1:0] lock_idx, lock_idx_next;

  // While locked, the locked requester owns the grant regardless of its valid.
  always_comb begin
    grant     = pick_grant;
    grant_idx = pick_index;
    if (state == LOCK_LOCKED) begin
      grant           = '0;
      grant[lock_idx] = 1'b1;
      grant_idx       = lock_idx;
    end
  end

  // Lock on a non-last beat, release on the last beat of the locked requester.
  always_comb begin
    state_next    = state;
    lock_idx_next = lock_idx;
    case (state)
      LOCK_IDLE: begin
        if (rx_fire && !receiver_last[grant_idx]) begin
          state_next    = LOCK_LOCKED;
          lock_idx_next = grant_idx;
        end
      end
      LOCK_LOCKED: begin
        if (rx_fire && receiver_last[grant_idx]) begin
          state_next = LOCK_IDLE;
        end
      end
      default: state_next = LOCK_IDLE;
    endcase
  end

  // Lock state register; reset drops any packet in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= LOCK_IDLE;
      lock_idx <= '0;
    end else begin
      state    <= state_next;
      lock_idx <= lock_idx_next;
    end
  end
`else
  assign grant     = pick_grant;
  assign grant_idx = pick_index;
`endif

  assign slot_free      = !sender_valid || sender_ready;
  assign receiver_ready = reset ? '0 : (grant & {COUNT{slot_free}});
  assign rx_fire        = |(receiver_ready & receiver_valid);

  // Sender slot and round-robin pointer: load on a receiver transfer,
  // empty when the beat leaves with nothing behind it.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the data register is reset too so nothing stale is visible after reset.
      sender_valid  <= 1'b0;
      sender_source <= '0;
      sender_data   <= '0;
      pointer       <= IW'(COUNT - 1);
    end else if (rx_fire) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      sender_valid  <= 1'b1;
      sender_source <= grant_idx;
      sender_data   <= receiver_data[int'(grant_idx)*WIDTH +: WIDTH];
      pointer       <= grant_idx;
    end else if (sender_ready) begin
      sender_valid  <= 1'b0;
    end
  end

endmodule
